// File: rtl/alu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile_pkg
// Description : Shared widths and register-index names for the ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_regfile_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [REG_ADDR_W-1:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4,
        R5 = 3'd5,
        R6 = 3'd6,
        R7 = 3'd7
    } reg_idx_e;

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdport
// Description : One asynchronous read port: enable gating, write bypass and
//               zero-register masking over the parent's storage array.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport #(
    parameter int N       = 8,
    parameter int M       = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic [(2**M)-1:0][N-1:0] mem,
    input  logic                     rst,
    input  logic                     write,
    input  logic [M-1:0]             waddr,
    input  logic [N-1:0]             wd,
    input  logic [M-1:0]             addr,
    input  logic                     en,
    output logic [N-1:0]             q
);

    logic w_is_zero_reg;
    logic w_bypass_hit;

    assign w_is_zero_reg = (ZERO_R0 != 0) && (addr == '0);
    // Reset wins over a write, so the in-flight data must not be forwarded.
    assign w_bypass_hit  = (BYPASS != 0) && write && !rst && (addr == waddr);

    always_comb begin
        q = '0;
        if (en && !w_is_zero_reg) begin
            if (w_bypass_hit) begin
                q = wd;
            end else begin
                q = mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : 2**M x N register file feeding the ALU operands, with two
//               asynchronous read ports and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int N       = DATA_W,
    parameter int M       = REG_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] wd,
    input  logic [M-1:0] waddr,
    input  logic         write,
    input  logic [M-1:0] ra,
    input  logic         readA,
    input  logic [M-1:0] rb,
    input  logic         readB,
    output logic [N-1:0] qa,
    output logic [N-1:0] qb
);

    logic [(2**M)-1:0][N-1:0] r_mem;
    logic                     w_wr_en;

    // Writes to a hard-wired zero register are dropped at the source.
    assign w_wr_en = write && !((ZERO_R0 != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= wd;
        end
    end

    regfile_rdport #(
        .N       (N),
        .M       (M),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_rdport_a (
        .mem   (r_mem),
        .rst   (rst),
        .write (write),
        .waddr (waddr),
        .wd    (wd),
        .addr  (ra),
        .en    (readA),
        .q     (qa)
    );

    regfile_rdport #(
        .N       (N),
        .M       (M),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_rdport_b (
        .mem   (r_mem),
        .rst   (rst),
        .write (write),
        .waddr (waddr),
        .wd    (wd),
        .addr  (rb),
        .en    (readB),
        .q     (qb)
    );

endmodule
`default_nettype wire

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Register file directly upstream of the ALU in the datapath. It supplies the ALU's two operands from one read port each and accepts ALU results (or external data) through one write port.
- 2**M words of N bits.
- Two independent asynchronous read ports (A feeds ALU `a`, B feeds ALU `b`) and one synchronous write port.
- Optional write-to-read bypass and optional hard-wired zero register.

Parameters:
- N, 8, data width; must match the ALU width parameter.
- M, 3, address width; depth = 2**M.
- BYPASS, 1, 1 = read of the address being written returns `wd` in the same cycle; 0 = old contents until after the edge.
- ZERO_R0, 0, 1 = register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock; rising edge active.
- rst  in  1  synchronous, active-high reset.
- wd  in  N  write data (normally the ALU `sum` or external input).
- waddr  in  M  write address.
- write  in  1  write enable.
- ra  in  M  read address, port A.
- readA  in  1  read enable, port A.
- rb  in  M  read address, port B.
- readB  in  1  read enable, port B.
- qa  out  N  port A data, to ALU operand `a`.
- qb  out  N  port B data, to ALU operand `b`.

Behaviour:
- Storage: array of 2**M registers of N bits, updated only on the rising edge of `clk`.
- Reset:
  - At a rising edge with `rst`=1, every register is cleared to 0.
  - `write` is ignored in that cycle; reset wins over a simultaneous write.
  - Reset mid-sequence discards all prior contents.
  - After the reset edge, `qa`/`qb` read 0 for any address.
  - Before the first edge, contents are X; benches must reset first.
- Write:
  - At a rising edge with `rst`=0 and `write`=1, `mem[waddr]` <= `wd`.
  - With `write`=0 the array holds.
  - If ZERO_R0=1 and `waddr`=0, the write is dropped.
- Read (combinational, zero latency):
  - `qa` = 0 when `readA`=0; otherwise `mem[ra]`. `qb` is identical using `readB`/`rb`.
  - Disabled ports drive 0, not X and not hold.
  - ZERO_R0=1 and address 0: read returns 0 regardless of array contents.
  - Both ports may read the same address simultaneously and each returns the same value.
- Bypass:
  - BYPASS=1, `write`=1, `rst`=0, read enabled and read address == `waddr`: port returns `wd` combinationally in the same cycle.
  - The bypass is suppressed for address 0 when ZERO_R0=1.
  - BYPASS=0: port returns the old value until after the edge.
- Timing relation to the ALU:
  - The ALU registers its outputs, so a result written back via `wd` is readable by the next operation as follows.
  - BYPASS=1: in the cycle the write is presented.
  - BYPASS=0: one cycle after the write edge.
- Width rules:
  - No arithmetic performed.
  - Addresses are full-range; no out-of-range case exists.
  - X on an address with its enable low must not propagate to the output (output is 0).
- The write port and both read ports are fully independent; any combination may occur in one cycle.

Decomposition:
- Shared package/include holds:
  - `DATA_W` (8) and `REG_ADDR_W` (3) constants, shared with the ALU and datapath top.
  - An enumerated register-index constant set R0..R7, used by the controller and benches.
- One natural sub-module: `regfile_rdport`. It is the read mux with enable gating, bypass compare and zero-register masking. It is instantiated twice (ports A and B); the array and write logic stay in the parent.

Test Plan:
1. Reset clear: fill all 8 registers with 0xA5, assert `rst` 1 cycle, then read A=0..7 and B=7..0 with both enables → `qa`=`qb`=0x00 for every address.
2. Write/readback: write r2=0x02, r4=0x04 on consecutive edges; then `ra`=2, `rb`=4, both enables → `qa`=0x02, `qb`=0x04. This is the ALU add stimulus; the result sum written to r5 reads back 0x06.
3. Enable gating: r3=0x7F; `ra`=3 with `readA`=0, and `rb`=X with `readB`=0 → `qa`=0x00, `qb`=0x00 (no X).
4. Bypass: BYPASS=1, r1=0x11; in one cycle `write`=1, `waddr`=1, `wd`=0x22, `ra`=1 → `qa`=0x22 before the edge. The same stimulus with BYPASS=0 → `qa`=0x11 before the edge and 0x22 after.
5. Reset vs write: `rst`=1 and `write`=1 (`waddr`=6, `wd`=0xFF) in the same cycle → r6 reads 0x00 afterwards.
6. Zero register: ZERO_R0=1; write r0=0x55, then read `ra`=`rb`=0 → `qa`=`qb`=0x00. The bypass case with `waddr`=0 also yields 0x00.
